// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction-store loader, its bus interface and
// the processor/instruction-memory peers that use the same geometry.
package inst_loader_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned INST_W = 9;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        INST_HI = 3'd3,
        INST_LO = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6,
        ERROR   = 3'd7
    } load_state_t;

endpackage

// File: rtl/inst_loader_if.sv
// Control, byte-stream and memory-write signals of the instruction loader.
// master drives the stream and observes status; slave is the loader itself.
interface inst_loader_if;
    import inst_loader_pkg::*;

    logic              Start;
    logic [7:0]        ByteIn;
    logic              ByteValid;
    logic              ByteReady;
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [INST_W-1:0] WrData;
    logic              CoreHold;
    logic              Done;
    logic              Error;

    modport master (
        output Start, ByteIn, ByteValid,
        input  ByteReady, WrEn, WrAddr, WrData, CoreHold, Done, Error
    );

    modport slave (
        input  Start, ByteIn, ByteValid,
        output ByteReady, WrEn, WrAddr, WrData, CoreHold, Done, Error
    );

endinterface

// File: rtl/inst_loader.sv
// Receives a length-prefixed byte stream, packs byte pairs into 9-bit words,
// writes them to sequential instruction addresses and verifies an XOR trailer.
module inst_loader
    import inst_loader_pkg::*;
(
    input logic          Clk,
    input logic          Reset_n,
    inst_loader_if.slave lb
);

    load_state_t       state;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        csum;
    logic              inst_hi;
    logic              ready;
    logic              accept;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [INST_W-1:0] wr_data;
    logic              core_hold;
    logic              done;
    logic              error;

    always_comb begin
        ready = 1'b0;
        case (state)
            LEN_HI, LEN_LO, INST_HI, INST_LO, CHECK: ready = 1'b1;
            default:                                 ready = 1'b0;
        endcase
    end

    assign accept = lb.ByteValid && ready;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            count     <= '0;
            idx       <= '0;
            csum      <= '0;
            inst_hi   <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            core_hold <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (lb.Start) begin
                        state     <= LEN_HI;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        csum      <= '0;
                        idx       <= '0;
                        core_hold <= 1'b1;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        csum <= csum ^ lb.ByteIn;
                        if (lb.ByteIn[7:4] != 4'd0) begin
                            state <= ERROR;
                            error <= 1'b1;
                        end else begin
                            count <= {lb.ByteIn[3:0], 8'd0};
                            state <= LEN_LO;
                        end
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        csum       <= csum ^ lb.ByteIn;
                        count[7:0] <= lb.ByteIn;
                        // Empty image: skip straight to the trailer.
                        if ({count[11:8], lb.ByteIn} == 12'd0)
                            state <= CHECK;
                        else
                            state <= INST_HI;
                    end
                end
                INST_HI: begin
                    if (accept) begin
                        csum <= csum ^ lb.ByteIn;
                        if (lb.ByteIn[7:1] != 7'd0) begin
                            state <= ERROR;
                            error <= 1'b1;
                        end else begin
                            inst_hi <= lb.ByteIn[0];
                            state   <= INST_LO;
                        end
                    end
                end
                INST_LO: begin
                    if (accept) begin
                        csum    <= csum ^ lb.ByteIn;
                        wr_en   <= 1'b1;
                        wr_addr <= idx;
                        wr_data <= {inst_hi, lb.ByteIn};
                        idx     <= idx + 12'd1;
                        if (idx + 12'd1 == count)
                            state <= CHECK;
                        else
                            state <= INST_HI;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (lb.ByteIn == csum) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign lb.ByteReady = ready;
    assign lb.WrEn      = wr_en;
    assign lb.WrAddr    = wr_addr;
    assign lb.WrData    = wr_data;
    assign lb.CoreHold  = core_hold;
    assign lb.Done      = done;
    assign lb.Error     = error;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: streams hand-built images and checks writes,
// status levels, CoreHold and asynchronous reset against precomputed values.
module tb_inst_loader;
    import inst_loader_pkg::*;

    logic Clk;
    logic Reset_n;
    int   total;
    int   bad;
    logic [ADDR_W-1:0] wa_q[$];
    logic [INST_W-1:0] wd_q[$];

    inst_loader_if bus ();

    inst_loader dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .lb      (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Reset_n && bus.WrEn) begin
            wa_q.push_back(bus.WrAddr);
            wd_q.push_back(bus.WrData);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned n;
        n = 0;
        @(negedge Clk);
        bus.ByteIn    = b;
        bus.ByteValid = 1'b1;
        while (!bus.ByteReady && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (!bus.ByteReady)
            check("ready_timeout", 32'(bus.ByteReady), 32'd1);
        @(posedge Clk);
        #1 bus.ByteValid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s[], input int unsigned len);
        for (int unsigned i = 0; i < len; i++)
            send_byte(s[i]);
    endtask

    task automatic settle();
        repeat (3) @(negedge Clk);
    endtask

    logic [7:0] img[];

    initial begin
        total = 0;
        bad   = 0;
        bus.Start     = 1'b0;
        bus.ByteIn    = 8'h00;
        bus.ByteValid = 1'b0;
        Reset_n       = 1'b0;
        repeat (2) @(negedge Clk);

        check("rst_ready", 32'(bus.ByteReady), 32'd0);
        check("rst_hold",  32'(bus.CoreHold),  32'd0);
        check("rst_done",  32'(bus.Done),      32'd0);
        check("rst_error", 32'(bus.Error),     32'd0);
        check("rst_wren",  32'(bus.WrEn),      32'd0);
        Reset_n = 1'b1;

        // XOR of 00 03 01 7F 00 53 01 3D is 0x12.
        img = '{8'h00, 8'h03, 8'h01, 8'h7F, 8'h00, 8'h53, 8'h01, 8'h3D, 8'h12};
        pulse_start();
        check("t1_hold_start",  32'(bus.CoreHold),  32'd1);
        check("t1_ready_start", 32'(bus.ByteReady), 32'd1);
        send_seq(img, 9);
        @(negedge Clk);
        check("t1_done",  32'(bus.Done),     32'd1);
        check("t1_error", 32'(bus.Error),    32'd0);
        check("t1_hold",  32'(bus.CoreHold), 32'd0);
        settle();
        check("t1_nwr", 32'(wa_q.size()), 32'd3);
        if (wa_q.size() == 3) begin
            check("t1_a0", 32'(wa_q[0]), 32'h000);
            check("t1_d0", 32'(wd_q[0]), 32'h17F);
            check("t1_a1", 32'(wa_q[1]), 32'h001);
            check("t1_d1", 32'(wd_q[1]), 32'h053);
            check("t1_a2", 32'(wa_q[2]), 32'h002);
            check("t1_d2", 32'(wd_q[2]), 32'h13D);
        end
        check("t1_addr_hold", 32'(bus.WrAddr), 32'h002);
        check("t1_data_hold", 32'(bus.WrData), 32'h13D);
        wa_q.delete();
        wd_q.delete();

        img[8] = 8'h3E;
        pulse_start();
        check("t2_done_clr", 32'(bus.Done), 32'd0);
        send_seq(img, 9);
        @(negedge Clk);
        check("t2_error", 32'(bus.Error),    32'd1);
        check("t2_done",  32'(bus.Done),     32'd0);
        check("t2_hold",  32'(bus.CoreHold), 32'd1);
        settle();
        check("t2_nwr", 32'(wa_q.size()), 32'd3);
        wa_q.delete();
        wd_q.delete();

        img = '{8'h00, 8'h00, 8'h00};
        pulse_start();
        check("t3_error_clr", 32'(bus.Error), 32'd0);
        send_seq(img, 3);
        @(negedge Clk);
        check("t3_done", 32'(bus.Done),     32'd1);
        check("t3_hold", 32'(bus.CoreHold), 32'd0);
        settle();
        check("t3_nwr", 32'(wa_q.size()), 32'd0);

        pulse_start();
        send_byte(8'h10);
        @(negedge Clk);
        check("t4_error", 32'(bus.Error),     32'd1);
        check("t4_ready", 32'(bus.ByteReady), 32'd0);
        check("t4_done",  32'(bus.Done),      32'd0);
        settle();
        check("t4_nwr", 32'(wa_q.size()), 32'd0);

        img = '{8'h00, 8'h01, 8'h02};
        pulse_start();
        send_seq(img, 3);
        @(negedge Clk);
        check("t5_error", 32'(bus.Error), 32'd1);
        check("t5_hold",  32'(bus.CoreHold), 32'd1);
        settle();
        check("t5_nwr", 32'(wa_q.size()), 32'd0);

        // Gaps and Start pulses mid-load; XOR of 00 02 01 7F 00 53 is 0x2F.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        repeat (5) @(negedge Clk);
        pulse_start();
        send_byte(8'h01);
        repeat (5) @(negedge Clk);
        send_byte(8'h7F);
        pulse_start();
        repeat (5) @(negedge Clk);
        send_byte(8'h00);
        send_byte(8'h53);
        send_byte(8'h2F);
        @(negedge Clk);
        check("t6_done",  32'(bus.Done),  32'd1);
        check("t6_error", 32'(bus.Error), 32'd0);
        settle();
        check("t6_nwr", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            check("t6_a0", 32'(wa_q[0]), 32'h000);
            check("t6_d0", 32'(wd_q[0]), 32'h17F);
            check("t6_a1", 32'(wa_q[1]), 32'h001);
            check("t6_d1", 32'(wd_q[1]), 32'h053);
        end
        wa_q.delete();
        wd_q.delete();

        img = '{8'h00, 8'h02, 8'h01, 8'h7F, 8'h01};
        pulse_start();
        send_seq(img, 5);
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("t7_ready", 32'(bus.ByteReady), 32'd0);
        check("t7_hold",  32'(bus.CoreHold),  32'd0);
        check("t7_wren",  32'(bus.WrEn),      32'd0);
        check("t7_addr",  32'(bus.WrAddr),    32'd0);
        check("t7_data",  32'(bus.WrData),    32'd0);
        check("t7_done",  32'(bus.Done),      32'd0);
        check("t7_error", 32'(bus.Error),     32'd0);
        check("t7_nwr", 32'(wa_q.size()), 32'd1);
        @(negedge Clk);
        Reset_n = 1'b1;
        bus.ByteValid = 1'b1;
        bus.ByteIn    = 8'h00;
        repeat (2) @(negedge Clk);
        check("t7_idle_ready", 32'(bus.ByteReady), 32'd0);
        bus.ByteValid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
